// File: rtl/apb_read_bank.sv
// apb_read_bank: APB slave that returns a snapshot of one of NUM_CH channel
// words per read, with WAIT_CYC wait states before pready.
//
// Parameters:
//   DATA_W   - width of each channel word and of prdata
//   NUM_CH   - number of readable channels (2..64)
//   WAIT_CYC - wait states inserted before pready (0..15)
//   ADDR_W   - word-index address width, derived from NUM_CH
//
// Ports:
//   pclk, preset_n - clock (rising edge) and asynchronous active-low reset
//   psel, penable, pwrite, paddr - APB request
//   ch_data  - flattened channel words, channel i at [i*DATA_W +: DATA_W]
//   pready, prdata, pslverr - APB response
//
// pready/prdata/pslverr are combinational from the FSM state, the captured
// flags and psel/penable, as the APB handshake requires.
//
// Optional feature macro: APB_READ_BANK_PSLVERR_EN
//   defined   - pslverr asserts with pready for writes and out-of-range reads
//   undefined - pslverr tied to 0; those transfers complete silently
module apb_read_bank #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned ADDR_W   = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     pready,
    output logic [DATA_W-1:0]        prdata,
    output logic                     pslverr
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hold;
    logic                dir_wr;
    logic                err;

    logic                setup_c;
    logic                done_c;
    logic                abort_c;
    logic                oor_c;
    logic [DATA_W-1:0]   word_c;

    // Setup phase seen in IDLE; psel&penable in IDLE is a protocol error and ignored.
    assign setup_c = (state == S_IDLE) && psel && !penable;
    assign done_c  = (state == S_ACCESS) && psel && penable && (cnt == '0);
    assign abort_c = (state == S_ACCESS) && !psel;
    assign oor_c   = 32'(paddr) >= NUM_CH;

    // Channel word mux; indices beyond NUM_CH fall through to zero.
    always_comb begin
        word_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(paddr) == i) begin
                word_c = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (setup_c) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (abort_c || done_c) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Snapshot, direction/error flags and wait counter; all discarded on exit from ACCESS.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt    <= '0;
            hold   <= '0;
            dir_wr <= 1'b0;
            err    <= 1'b0;
        end else if (setup_c) begin
            cnt    <= CNT_W'(WAIT_CYC);
            hold   <= oor_c ? '0 : word_c;
            dir_wr <= pwrite;
            err    <= oor_c;
        end else if (abort_c || done_c) begin
            cnt    <= '0;
            hold   <= '0;
            dir_wr <= 1'b0;
            err    <= 1'b0;
        end else if ((state == S_ACCESS) && (cnt != '0)) begin
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // Response outputs.
    always_comb begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        if (done_c) begin
            pready = 1'b1;
            if (!dir_wr && !err) begin
                prdata = hold;
            end
`ifdef APB_READ_BANK_PSLVERR_EN
            pslverr = dir_wr || err;
`else
            pslverr = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_apb_read_bank.sv
// tb_apb_read_bank: directed table-driven bench for apb_read_bank.
// Four instances share one APB bus: d0 (4 ch, 0 wait), d1 (4 ch, 3 wait),
// d2 (4 ch, 2 wait), d3 (3 ch, 0 wait). Each check targets one instance.
module tb_apb_read_bank;

`ifdef APB_READ_BANK_PSLVERR_EN
    localparam bit PSLV = 1'b1;
`else
    localparam bit PSLV = 1'b0;
`endif

    logic        pclk;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [1:0]  paddr;
    logic [31:0] ch_data;

    logic [3:0]       pready_v;
    logic [3:0][7:0]  prdata_v;
    logic [3:0]       pslverr_v;

    int checks = 0;
    int errors = 0;
    int waits[4] = '{0, 3, 2, 0};

    apb_read_bank #(.DATA_W(8), .NUM_CH(4), .WAIT_CYC(0)) u_d0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .ch_data(ch_data),
        .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]));

    apb_read_bank #(.DATA_W(8), .NUM_CH(4), .WAIT_CYC(3)) u_d1 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .ch_data(ch_data),
        .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]));

    apb_read_bank #(.DATA_W(8), .NUM_CH(4), .WAIT_CYC(2)) u_d2 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .ch_data(ch_data),
        .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2]));

    apb_read_bank #(.DATA_W(8), .NUM_CH(3), .WAIT_CYC(0)) u_d3 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .ch_data(ch_data[23:0]),
        .pready(pready_v[3]), .prdata(prdata_v[3]), .pslverr(pslverr_v[3]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One APB transfer on the shared bus; ch1 is applied in the first access cycle.
    task automatic xfer(input int d, input bit we, input logic [1:0] a,
                        input logic [31:0] ch0, input logic [31:0] ch1,
                        input logic [7:0] exp_d, input bit exp_e, input string nm);
        int n;
        bit done;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = we; paddr = a; ch_data = ch0;
        @(posedge pclk); #1;
        penable = 1'b1; ch_data = ch1;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            n++;
            @(negedge pclk);
            if (pready_v[d]) begin
                done = 1'b1;
            end else begin
                @(posedge pclk); #1;
            end
        end
        chk($sformatf("%s_latency", nm), done ? 32'(n) : 32'hFFFF_FFFF, 32'(waits[d] + 1));
        chk($sformatf("%s_prdata", nm), 32'(prdata_v[d]), 32'(exp_d));
        chk($sformatf("%s_pslverr", nm), 32'(pslverr_v[d]), 32'(exp_e));
    endtask

    typedef struct {
        int          d;
        bit          we;
        logic [1:0]  a;
        logic [31:0] ch0;
        logic [31:0] ch1;
        logic [7:0]  exp_d;
        bit          exp_e;
    } vec_t;

    vec_t vt[10];

    initial begin
        int seen;

        vt[0] = '{0, 1'b0, 2'd2, 32'h44332211, 32'h44332211, 8'h33, 1'b0};
        vt[1] = '{0, 1'b0, 2'd0, 32'h44332211, 32'h44332211, 8'h11, 1'b0};
        vt[2] = '{0, 1'b0, 2'd3, 32'h44332211, 32'h44332211, 8'h44, 1'b0};
        vt[3] = '{0, 1'b1, 2'd1, 32'h44332211, 32'h44332211, 8'h00, PSLV};
        vt[4] = '{3, 1'b0, 2'd3, 32'h44332211, 32'h44332211, 8'h00, PSLV};
        vt[5] = '{3, 1'b1, 2'd0, 32'h44332211, 32'h44332211, 8'h00, PSLV};
        vt[6] = '{3, 1'b0, 2'd2, 32'h44332211, 32'h44332211, 8'h33, 1'b0};
        vt[7] = '{1, 1'b0, 2'd3, 32'h44332211, 32'h44332211, 8'h44, 1'b0};
        vt[8] = '{1, 1'b0, 2'd1, 32'h44332211, 32'h4433FF11, 8'h22, 1'b0};
        vt[9] = '{0, 1'b0, 2'd1, 32'hA5B6C7D8, 32'h00000000, 8'hC7, 1'b0};

        preset_n = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 2'd0;
        ch_data  = 32'h44332211;

        // Reset state.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset_pready", 32'(pready_v), 32'h0);
        chk("reset_prdata", 32'(prdata_v), 32'h0);
        chk("reset_pslverr", 32'(pslverr_v), 32'h0);
        @(posedge pclk); #1;
        preset_n = 1'b1;

        // Directed vector table, separated by an idle cycle.
        for (int i = 0; i < 10; i++) begin
            xfer(vt[i].d, vt[i].we, vt[i].a, vt[i].ch0, vt[i].ch1,
                 vt[i].exp_d, vt[i].exp_e, $sformatf("vec%0d", i));
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0;
        end

        // Abort after one access cycle on d2, then protocol-error access with no setup.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 2'd1; ch_data = 32'h44332211;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("abort_cycle1_pready", 32'(pready_v[2]), 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge pclk);
            if (pready_v[2]) seen++;
        end
        chk("abort_no_completion", 32'(seen), 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;

        // Back-to-back reads on d2 with no idle gap.
        xfer(2, 1'b0, 2'd0, 32'h44332211, 32'h44332211, 8'h11, 1'b0, "b2b_first");
        xfer(2, 1'b0, 2'd3, 32'h44332211, 32'h44332211, 8'h44, 1'b0, "b2b_second");
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;

        // Reset in the second access cycle of a d1 read.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 2'd2;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #2;
        preset_n = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready_v[1]), 32'h0);
        chk("midrst_prdata", 32'(prdata_v[1]), 32'h0);
        chk("midrst_pslverr", 32'(pslverr_v[1]), 32'h0);
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge pclk);
            if (pready_v[1]) seen++;
        end
        chk("midrst_no_completion", 32'(seen), 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;

        // Fresh transfer after reset.
        xfer(1, 1'b0, 2'd2, 32'h44332211, 32'h44332211, 8'h33, 1'b0, "post_reset");
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
